// File: rtl/decode_stage.sv
// decode_stage
// Registered instruction-decode pipeline stage with valid/ready handshakes on
// both sides. Each accepted instruction is split into opcode, destination
// register, source register and immediate; the immediate is sign- or
// zero-extended according to the opcode, and opcodes that are not legal are
// flagged but still passed downstream. A main entry drives the outputs and a
// skid entry absorbs one extra instruction, so the stage sustains one
// instruction per cycle while keeping in_ready a pure register.
//
// Ports:
//   clk, reset         clock and synchronous active-high reset
//   flush              discard all buffered instructions, clear decode_count
//   in_valid/in_ready  upstream handshake, instruction word
//   out_valid/out_ready downstream handshake
//   opcode, reg_dest, reg_source, imm_ext, illegal  decoded fields (registered)
//   decode_count       output handshakes since reset/flush, wraps
module decode_stage #(
    parameter int          INSTRUCTION_WIDTH = 16,
    parameter int          WIDTH_OPCODE      = 4,
    parameter int          REGFILE_ADDR_BITS = 3,
    parameter int          IMMEDIATE_WIDTH   = 6,
    parameter int          DATA_WIDTH        = 16,
    parameter logic [15:0] IMM_SIGNED_MASK   = 16'h00F0,
    parameter logic [15:0] VALID_OP_MASK     = 16'h7FFF,
    parameter int          CNT_WIDTH         = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [INSTRUCTION_WIDTH-1:0] instruction,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH_OPCODE-1:0]      opcode,
    output logic [REGFILE_ADDR_BITS-1:0] reg_dest,
    output logic [REGFILE_ADDR_BITS-1:0] reg_source,
    output logic [DATA_WIDTH-1:0]        imm_ext,
    output logic                         illegal,
    output logic [CNT_WIDTH-1:0]         decode_count
);

    localparam int NUM_OPS   = 1 << WIDTH_OPCODE;
    localparam int MASK_BITS = 16;
    localparam int ENTRY_W   = WIDTH_OPCODE + 2 * REGFILE_ADDR_BITS + DATA_WIDTH + 1;

    // Stored entry after reset: all fields zero, illegal reflects opcode 0.
    localparam logic [ENTRY_W-1:0] ENTRY_RESET = {{(ENTRY_W-1){1'b0}}, ~VALID_OP_MASK[0]};

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] TWO   = 2'd2;

    // ------------------------------------------------------------------
    // Per-opcode lookup tables. Opcodes past the end of the 16-bit masks
    // read as 0: zero-extended and illegal.
    // ------------------------------------------------------------------
    logic [NUM_OPS-1:0] signed_tab;
    logic [NUM_OPS-1:0] legal_tab;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_OPS; gi++) begin : g_op_tab
            if (gi < MASK_BITS) begin : g_in_mask
                assign signed_tab[gi] = IMM_SIGNED_MASK[gi];
                assign legal_tab[gi]  = VALID_OP_MASK[gi];
            end else begin : g_out_mask
                assign signed_tab[gi] = 1'b0;
                assign legal_tab[gi]  = 1'b0;
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Combinational decode of the incoming word
    // ------------------------------------------------------------------
    logic [WIDTH_OPCODE-1:0]      dec_opcode;
    logic [REGFILE_ADDR_BITS-1:0] dec_dest;
    logic [REGFILE_ADDR_BITS-1:0] dec_source;
    logic [IMMEDIATE_WIDTH-1:0]   dec_imm;
    logic [DATA_WIDTH-1:0]        dec_imm_ext;
    logic                         dec_signed;
    logic                         dec_illegal;
    logic [ENTRY_W-1:0]           dec_entry;

    assign dec_opcode  = instruction[INSTRUCTION_WIDTH-1 -: WIDTH_OPCODE];
    assign dec_dest    = instruction[INSTRUCTION_WIDTH-WIDTH_OPCODE-1 -: REGFILE_ADDR_BITS];
    assign dec_source  = instruction[INSTRUCTION_WIDTH-WIDTH_OPCODE-REGFILE_ADDR_BITS-1 -: REGFILE_ADDR_BITS];
    assign dec_imm     = instruction[IMMEDIATE_WIDTH-1:0];
    assign dec_signed  = signed_tab[dec_opcode];
    assign dec_illegal = ~legal_tab[dec_opcode];

    generate
        if (DATA_WIDTH > IMMEDIATE_WIDTH) begin : g_ext
            assign dec_imm_ext = {{(DATA_WIDTH-IMMEDIATE_WIDTH){dec_signed & dec_imm[IMMEDIATE_WIDTH-1]}}, dec_imm};
        end else begin : g_no_ext
            assign dec_imm_ext = dec_imm;
        end
    endgenerate

    assign dec_entry = {dec_opcode, dec_dest, dec_source, dec_imm_ext, dec_illegal};

    // ------------------------------------------------------------------
    // Two-entry buffer control
    // ------------------------------------------------------------------
    logic [1:0]           state_reg, state_next;
    logic [ENTRY_W-1:0]   main_reg;
    logic [ENTRY_W-1:0]   skid_reg;
    logic                 in_ready_reg;
    logic                 out_valid_reg;
    logic [CNT_WIDTH-1:0] count_reg;

    logic accept;
    logic pop;
    logic load_main_new;
    logic load_main_skid;
    logic load_skid;

    assign accept = in_valid & in_ready_reg;
    assign pop    = out_valid_reg & out_ready;

    always_comb begin
        state_next     = state_reg;
        load_main_new  = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_reg)
            EMPTY: begin
                if (accept) begin
                    state_next    = ONE;
                    load_main_new = 1'b1;
                end
            end
            ONE: begin
                if (accept && !pop) begin
                    state_next = TWO;
                    load_skid  = 1'b1;
                end else if (accept && pop) begin
                    load_main_new = 1'b1;
                end else if (pop) begin
                    state_next = EMPTY;
                end
            end
            TWO: begin
                // in_ready is low here, so only the drain of main can happen
                if (pop) begin
                    state_next     = ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: state_next = EMPTY;
        endcase
        // flush wins over any handshake in the same cycle
        if (flush) begin
            state_next     = EMPTY;
            load_main_new  = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= EMPTY;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            count_reg     <= '0;
            main_reg      <= ENTRY_RESET;
            skid_reg      <= ENTRY_RESET;
        end else begin
            state_reg     <= state_next;
            // handshake flags are registered copies of the next state
            in_ready_reg  <= (state_next != TWO);
            out_valid_reg <= (state_next != EMPTY);
            if (load_main_new) begin
                main_reg <= dec_entry;
            end else if (load_main_skid) begin
                main_reg <= skid_reg;
            end
            if (load_skid) begin
                skid_reg <= dec_entry;
            end
            if (flush) begin
                count_reg <= '0;
            end else if (pop) begin
                count_reg <= count_reg + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

    assign in_ready     = in_ready_reg;
    assign out_valid    = out_valid_reg;
    assign decode_count = count_reg;
    assign {opcode, reg_dest, reg_source, imm_ext, illegal} = main_reg;

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: directed scenarios followed by randomized
// traffic, all compared against a queue-based reference model.
module tb_decode_stage;

    localparam int          CNT_W      = 4;
    localparam int          SIGNED_MSK = 16'h00F0;
    localparam int          VALID_MSK  = 16'h7FFF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] instruction = 16'h0000;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  opcode;
    logic [2:0]  reg_dest;
    logic [2:0]  reg_source;
    logic [15:0] imm_ext;
    logic        illegal;
    logic [CNT_W-1:0] decode_count;

    decode_stage #(
        .INSTRUCTION_WIDTH (16),
        .WIDTH_OPCODE      (4),
        .REGFILE_ADDR_BITS (3),
        .IMMEDIATE_WIDTH   (6),
        .DATA_WIDTH        (16),
        .IMM_SIGNED_MASK   (16'h00F0),
        .VALID_OP_MASK     (16'h7FFF),
        .CNT_WIDTH         (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .instruction  (instruction),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .opcode       (opcode),
        .reg_dest     (reg_dest),
        .reg_source   (reg_source),
        .imm_ext      (imm_ext),
        .illegal      (illegal),
        .decode_count (decode_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  op;
        logic [2:0]  rd;
        logic [2:0]  rs;
        logic [15:0] imm;
        logic        ill;
    } rec_t;

    rec_t       model_q[$];
    int         model_cnt = 0;
    logic [3:0] delivered[$];
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Field extraction by plain arithmetic on the 16-bit word
    function automatic rec_t ref_decode(input logic [15:0] ins);
        rec_t r;
        int unsigned w, op, rd, rs, imm;
        bit sgn;
        w   = ins;
        op  = w / 4096;
        rd  = (w / 512) % 8;
        rs  = (w / 64) % 8;
        imm = w % 64;
        sgn = ((SIGNED_MSK >> op) & 1) == 1;
        r.op  = 4'(op);
        r.rd  = 3'(rd);
        r.rs  = 3'(rs);
        r.imm = 16'((sgn && imm >= 32) ? imm + 65536 - 64 : imm);
        r.ill = ((VALID_MSK >> op) & 1) == 0;
        return r;
    endfunction

    // One clock cycle: drive inputs, advance, update model, compare
    task automatic cycle(input logic v, input logic [15:0] ins, input logic rdy,
                         input logic fl, input logic rst);
        bit acc, pp;
        in_valid    = v;
        instruction = ins;
        out_ready   = rdy;
        flush       = fl;
        reset       = rst;
        acc = v && (model_q.size() < 2);
        pp  = (model_q.size() != 0) && rdy;
        if (out_valid && rdy && !fl && !rst) begin
            delivered.push_back(opcode);
            $display("deliver #%0d opcode=%0h rd=%0d rs=%0d imm=%h illegal=%0b count=%0d",
                     delivered.size(), opcode, reg_dest, reg_source, imm_ext, illegal, decode_count);
        end
        @(posedge clk);
        #1;
        if (rst || fl) begin
            model_q.delete();
            model_cnt = 0;
        end else begin
            if (pp) begin
                void'(model_q.pop_front());
                model_cnt = (model_cnt + 1) % (1 << CNT_W);
            end
            if (acc) model_q.push_back(ref_decode(ins));
        end
        check("in_ready", {31'd0, in_ready}, {31'd0, model_q.size() < 2});
        check("out_valid", {31'd0, out_valid}, {31'd0, model_q.size() != 0});
        check("count", 32'(decode_count), 32'(model_cnt));
        if (model_q.size() != 0) begin
            check("opcode", 32'(opcode), 32'(model_q[0].op));
            check("reg_dest", 32'(reg_dest), 32'(model_q[0].rd));
            check("reg_source", 32'(reg_source), 32'(model_q[0].rs));
            check("imm_ext", 32'(imm_ext), 32'(model_q[0].imm));
            check("illegal", 32'(illegal), 32'(model_q[0].ill));
        end
        if (rst) begin
            check("rst_opcode", 32'(opcode), 32'd0);
            check("rst_reg_dest", 32'(reg_dest), 32'd0);
            check("rst_reg_source", 32'(reg_source), 32'd0);
            check("rst_imm_ext", 32'(imm_ext), 32'd0);
            check("rst_illegal", 32'(illegal), 32'(((VALID_MSK & 1) == 0)));
        end
    endtask

    initial begin
        int base;

        // Reset
        cycle(0, 16'h0000, 0, 0, 1);
        cycle(0, 16'h0000, 0, 0, 1);
        cycle(0, 16'h0000, 0, 0, 0);

        // Single signed instruction
        cycle(1, 16'h5A3F, 1, 0, 0);
        check("t1_opcode", 32'(opcode), 32'd5);
        check("t1_reg_dest", 32'(reg_dest), 32'd5);
        check("t1_reg_source", 32'(reg_source), 32'd0);
        check("t1_imm", 32'(imm_ext), 32'hFFFF);
        check("t1_illegal", 32'(illegal), 32'd0);
        cycle(0, 16'h0000, 1, 0, 0);
        check("t1_count", 32'(decode_count), 32'd1);

        // Unsigned opcode and illegal opcode
        cycle(1, 16'h1A3F, 1, 0, 0);
        check("t2_imm", 32'(imm_ext), 32'h003F);
        cycle(1, 16'hF000, 1, 0, 0);
        check("t2_illegal", 32'(illegal), 32'd1);
        check("t2_valid", 32'(out_valid), 32'd1);
        cycle(0, 16'h0000, 1, 0, 0);

        // Backpressure: A,B accepted, C held
        base = delivered.size();
        cycle(1, 16'h3123, 0, 0, 0);
        cycle(1, 16'h4456, 0, 0, 0);
        check("bp_ready_low", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cycle(1, 16'h6789, 0, 0, 0);
            check("bp_stable", 32'(opcode), 32'd3);
            check("bp_ready_hold", 32'(in_ready), 32'd0);
        end
        cycle(1, 16'h6789, 1, 0, 0);
        check("bp_ready_back", 32'(in_ready), 32'd1);
        for (int i = 0; i < 4; i++) cycle((i == 0) ? 1'b1 : 1'b0, 16'h6789, 1, 0, 0);
        check("bp_ndeliv", 32'(delivered.size() - base), 32'd3);
        if (delivered.size() >= base + 3) begin
            check("bp_order_a", 32'(delivered[base]), 32'd3);
            check("bp_order_b", 32'(delivered[base+1]), 32'd4);
            check("bp_order_c", 32'(delivered[base+2]), 32'd6);
        end

        // Streaming 10 instructions
        cycle(0, 16'h0000, 1, 1, 0);
        base = delivered.size();
        for (int i = 0; i < 10; i++) cycle(1, 16'($urandom), 1, 0, 0);
        cycle(0, 16'h0000, 1, 0, 0);
        cycle(0, 16'h0000, 1, 0, 0);
        check("stream_count", 32'(decode_count), 32'd10);
        check("stream_ndeliv", 32'(delivered.size() - base), 32'd10);

        // Flush while holding two entries, with handshakes on both sides
        cycle(1, 16'h2111, 0, 0, 0);
        cycle(1, 16'h2222, 0, 0, 0);
        base = delivered.size();
        cycle(1, 16'h2333, 1, 1, 0);
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_ready", 32'(in_ready), 32'd1);
        check("flush_count", 32'(decode_count), 32'd0);
        cycle(0, 16'h0000, 1, 0, 0);
        check("flush_nodeliv", 32'(delivered.size() - base), 32'd0);

        // Counter wrap after 17 handshakes
        for (int i = 0; i < 17; i++) cycle(1, 16'($urandom), 1, 0, 0);
        cycle(0, 16'h0000, 1, 0, 0);
        check("wrap_count", 32'(decode_count), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, 16'($urandom), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 49) == 0, $urandom_range(0, 149) == 0);
        end

        // Reset mid-stream
        cycle(1, 16'h7abc, 0, 0, 0);
        cycle(1, 16'h8def, 0, 0, 0);
        cycle(1, 16'h9123, 1, 0, 1);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd1);
        check("mid_rst_count", 32'(decode_count), 32'd0);
        cycle(0, 16'h0000, 1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
